// File: rtl/flash_prog_phy.sv
// flash_prog_phy: word program PHY with AND-only flash semantics and a fixed busy time.
// Define FLASH_PROG_BLANK_CHK_EN to add the read-modify step and the 0->1 transition error.
module flash_prog_phy #(
  parameter int AddrW      = 10,
  parameter int DataW      = 32,
  parameter int ProgCycles = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             req_i,
  input  logic [AddrW-1:0] addr_i,
  input  logic             ovfl_i,
  input  logic [DataW-1:0] data_i,
  input  logic             prog_en_i,
  output logic             done_o,
  output logic             error_o,
  output logic             busy_o,
  output logic             mem_req_o,
  output logic             mem_we_o,
  output logic [AddrW-1:0] mem_addr_o,
  output logic [DataW-1:0] mem_wdata_o,
  input  logic [DataW-1:0] mem_rdata_i
);
  typedef enum logic [2:0] {IDLE, RD, CHK, PROG, WAIT, DONE} state_t;
  localparam logic [7:0] PC = 8'(ProgCycles);
  state_t           r_state, w_next;
  logic [AddrW-1:0] r_addr;
  logic [DataW-1:0] r_data;
  logic             r_err;
  logic [7:0]       r_cnt;
  logic             w_acc_err, w_rd, w_wr;
  logic [DataW-1:0] w_wval;
  assign w_acc_err = ovfl_i | ~prog_en_i;
  assign w_wr      = r_state == PROG;
`ifdef FLASH_PROG_BLANK_CHK_EN
  localparam state_t FIRST = RD;
  logic [DataW-1:0] r_rdata;
  logic             w_bit_err;
  assign w_bit_err = |(~mem_rdata_i & r_data);
  assign w_rd      = r_state == RD;
  assign w_wval    = r_rdata & r_data;
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) r_rdata <= '0;
    else if (r_state == CHK) r_rdata <= mem_rdata_i;
`else
  localparam state_t FIRST = PROG;
  logic w_unused;
  assign w_unused = ^mem_rdata_i;
  assign w_rd     = 1'b0;
  assign w_wval   = r_data;
`endif
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      r_state <= IDLE;
      r_addr  <= '0;
      r_data  <= '0;
      r_err   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && req_i) begin
        r_addr <= addr_i;
        r_data <= data_i;
        r_err  <= w_acc_err;
      end
`ifdef FLASH_PROG_BLANK_CHK_EN
      if (r_state == CHK) r_err <= w_bit_err;
`endif
      if (r_state == DONE) r_err <= 1'b0;
      if (r_state == PROG) r_cnt <= PC;
      else if (r_state == WAIT) r_cnt <= r_cnt - 8'd1;
    end
  // r_cnt holds ProgCycles on WAIT entry, so leaving at 1 gives exactly ProgCycles WAIT cycles
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = req_i ? (w_acc_err ? DONE : FIRST) : IDLE;
`ifdef FLASH_PROG_BLANK_CHK_EN
      RD:      w_next = CHK;
      CHK:     w_next = w_bit_err ? DONE : PROG;
`endif
      PROG:    w_next = (PC == 8'd0) ? DONE : WAIT;
      WAIT:    w_next = (r_cnt == 8'd1) ? DONE : WAIT;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end
  assign busy_o      = r_state != IDLE;
  assign done_o      = r_state == DONE;
  assign error_o     = done_o & r_err;
  assign mem_req_o   = w_rd | w_wr;
  assign mem_we_o    = w_wr;
  assign mem_addr_o  = mem_req_o ? r_addr : '0;
  assign mem_wdata_o = w_wr ? w_wval : '0;
endmodule
